cache_mem_arbiter: RTL and testbench

Shares the single burst memory port between the instruction cache (read-only) and the data cache (read and writeback). It grants one requester at a time with round-robin priority, serializes 256-bit dcache writebacks into four 64-bit beats, and steers the four returning read beats to the owning cache. It sits between both caches' downward-facing ports and the memory/bus adapter. One memory transaction is outstanding at a time.

---
 rtl/cache_mem_arbiter_if.sv | 46 ++++
 rtl/cache_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Shared memory-port bundle between the two caches and the burst port.
// The arbiter takes the slave side; the caches and memory model take the master side.
interface cache_mem_arbiter_if;
    logic [31:0]  ic_addr;
    logic         ic_read;
    logic         ic_ready;
    logic [63:0]  ic_rdata;
    logic [31:0]  ic_raddr;
    logic         ic_rvalid;

    logic [31:0]  dc_addr;
    logic         dc_read;
    logic         dc_write;
    logic [255:0] dc_wdata;
    logic         dc_ready;
    logic [63:0]  dc_rdata;
    logic [31:0]  dc_raddr;
    logic         dc_rvalid;

    logic [31:0]  bfp_addr;
    logic         bfp_read;
    logic         bfp_write;
    logic [63:0]  bfp_wdata;
    logic         bfp_ready;
    logic [63:0]  bfp_rdata;
    logic [31:0]  bfp_raddr;
    logic         bfp_rvalid;

    modport slave (
        input  ic_addr, ic_read,
        output ic_ready, ic_rdata, ic_raddr, ic_rvalid,
        input  dc_addr, dc_read, dc_write, dc_wdata,
        output dc_ready, dc_rdata, dc_raddr, dc_rvalid,
        output bfp_addr, bfp_read, bfp_write, bfp_wdata,
        input  bfp_ready, bfp_rdata, bfp_raddr, bfp_rvalid
    );

    modport master (
        output ic_addr, ic_read,
        input  ic_ready, ic_rdata, ic_raddr, ic_rvalid,
        output dc_addr, dc_read, dc_write, dc_wdata,
        input  dc_ready, dc_rdata, dc_raddr, dc_rvalid,
        input  bfp_addr, bfp_read, bfp_write, bfp_wdata,
        output bfp_ready, bfp_rdata, bfp_raddr, bfp_rvalid
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between icache and dcache.
// Serializes dcache line writebacks into 64-bit beats and steers read beats to the owner.
module cache_mem_arbiter (
    input  logic                 clk,
    input  logic                 rst,
    cache_mem_arbiter_if.slave   bus
);
    localparam int BEATS = 4;
    localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE, RD_CMD, RD_DATA, WR_BURST
    } state_t;

    typedef enum logic {
        OWN_IC = 1'b0,
        OWN_DC = 1'b1
    } owner_t;

    state_t       state, state_n;
    logic [1:0]   beat_cnt, beat_cnt_n;
    owner_t       last_grant, owner;
    logic [26:0]  line_q;
    logic [255:0] wdata_q;

    logic   ic_req, dc_req, grant;
    owner_t pick;

    assign ic_req = bus.ic_read;
    assign dc_req = bus.dc_read | bus.dc_write;

    // On a tie the requester that did not win last time is favoured.
    always_comb begin
        pick = OWN_IC;
        if (dc_req && (!ic_req || last_grant == OWN_IC))
            pick = OWN_DC;
    end

    assign grant = (state == IDLE) && (ic_req || dc_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= 2'd0;
            last_grant <= OWN_DC;
            owner      <= OWN_IC;
            line_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
            if (grant) begin
                owner      <= pick;
                last_grant <= pick;
                if (pick == OWN_DC) begin
                    line_q  <= bus.dc_addr[31:5];
                    wdata_q <= bus.dc_wdata;
                end else begin
                    line_q  <= bus.ic_addr[31:5];
                end
            end
        end
    end

    always_comb begin
        state_n       = state;
        beat_cnt_n    = beat_cnt;
        bus.bfp_addr  = 32'd0;
        bus.bfp_read  = 1'b0;
        bus.bfp_write = 1'b0;
        bus.bfp_wdata = 64'd0;
        bus.ic_ready  = 1'b0;
        bus.dc_ready  = 1'b0;
        bus.ic_rvalid = 1'b0;
        bus.dc_rvalid = 1'b0;

        unique case (state)
            IDLE: begin
                if (grant) begin
                    beat_cnt_n = 2'd0;
                    if (pick == OWN_DC && bus.dc_write)
                        state_n = WR_BURST;
                    else
                        state_n = RD_CMD;
                end
            end
            RD_CMD: begin
                bus.bfp_read = 1'b1;
                bus.bfp_addr = {line_q, 5'b0};
                if (bus.bfp_ready) begin
                    bus.ic_ready = (owner == OWN_IC);
                    bus.dc_ready = (owner == OWN_DC);
                    beat_cnt_n   = 2'd0;
                    state_n      = RD_DATA;
                end
            end
            RD_DATA: begin
                if (bus.bfp_rvalid) begin
                    bus.ic_rvalid = (owner == OWN_IC);
                    bus.dc_rvalid = (owner == OWN_DC);
                    beat_cnt_n    = beat_cnt + 2'd1;
                    if (beat_cnt == LAST_BEAT)
                        state_n = IDLE;
                end
            end
            WR_BURST: begin
                bus.bfp_write = 1'b1;
                bus.bfp_addr  = {line_q, 5'b0};
                bus.bfp_wdata = wdata_q[{beat_cnt, 6'b0} +: 64];
                if (bus.bfp_ready) begin
                    beat_cnt_n = beat_cnt + 2'd1;
                    if (beat_cnt == LAST_BEAT) begin
                        bus.dc_ready = 1'b1;
                        state_n      = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Data and tag are zero whenever the matching valid is low.
    assign bus.ic_rdata = bus.ic_rvalid ? bus.bfp_rdata : 64'd0;
    assign bus.ic_raddr = bus.ic_rvalid ? bus.bfp_raddr : 32'd0;
    assign bus.dc_rdata = bus.dc_rvalid ? bus.bfp_rdata : 64'd0;
    assign bus.dc_raddr = bus.dc_rvalid ? bus.bfp_raddr : 32'd0;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_cache_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    cache_mem_arbiter_if bus ();

    cache_mem_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (!rst)
            assert (!(bus.dc_read && bus.dc_write))
                else $error("dc_read and dc_write together");

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outs(input string tag);
        check({tag, "_rd"}, 64'(bus.bfp_read), 0);
        check({tag, "_wr"}, 64'(bus.bfp_write), 0);
        check({tag, "_irv"}, 64'(bus.ic_rvalid), 0);
        check({tag, "_drv"}, 64'(bus.dc_rvalid), 0);
    endtask

    // Runs one granted read: expects IDLE now, grant at next edge.
    task automatic read_txn(input bit exp_dc, input logic [31:0] line,
                            input int waits, input logic [63:0] base);
        check("pre_idle", 64'(bus.bfp_read), 0);
        tick();
        check("cmd_rd", 64'(bus.bfp_read), 1);
        check("cmd_addr", 64'(bus.bfp_addr), 64'(line));
        for (int w = 0; w < waits; w++) begin
            check("rdy_low", 64'(bus.ic_ready | bus.dc_ready), 0);
            tick();
            check("cmd_hold", 64'(bus.bfp_read), 1);
        end
        bus.bfp_ready = 1'b1;
        #1;
        check("ic_ready", 64'(bus.ic_ready), 64'(!exp_dc));
        check("dc_ready", 64'(bus.dc_ready), 64'(exp_dc));
        tick();
        bus.bfp_ready = 1'b0;
        if (exp_dc) bus.dc_read = 1'b0;
        else        bus.ic_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.bfp_rvalid = 1'b1;
            bus.bfp_rdata  = base + 64'(i);
            bus.bfp_raddr  = line;
            #1;
            if (exp_dc) begin
                check("dc_rvalid", 64'(bus.dc_rvalid), 1);
                check("dc_rdata", bus.dc_rdata, base + 64'(i));
                check("dc_raddr", 64'(bus.dc_raddr), 64'(line));
                check("ic_rv_off", 64'(bus.ic_rvalid), 0);
            end else begin
                check("ic_rvalid", 64'(bus.ic_rvalid), 1);
                check("ic_rdata", bus.ic_rdata, base + 64'(i));
                check("ic_raddr", 64'(bus.ic_raddr), 64'(line));
                check("dc_rv_off", 64'(bus.dc_rvalid), 0);
            end
            tick();
        end
        bus.bfp_rvalid = 1'b0;
        #1;
        idle_outs("post_rd");
    endtask

    initial begin
        logic [63:0] wbeat [4];
        bit          pat   [6];
        int          idx;

        rst = 1'b1;
        bus.ic_addr = '0; bus.ic_read = 1'b0;
        bus.dc_addr = '0; bus.dc_read = 1'b0;
        bus.dc_write = 1'b0; bus.dc_wdata = '0;
        bus.bfp_ready = 1'b0; bus.bfp_rdata = '0;
        bus.bfp_raddr = '0; bus.bfp_rvalid = 1'b0;
        tick(); tick();
        idle_outs("rst");
        check("rst_addr", 64'(bus.bfp_addr), 0);
        check("rst_rdy", 64'(bus.ic_ready | bus.dc_ready), 0);
        rst = 1'b0;
        tick();

        // icache alone, ready held off for 3 cycles
        bus.ic_addr = 32'h0000_1234;
        bus.ic_read = 1'b1;
        #1;
        read_txn(1'b0, 32'h0000_1220, 3, 64'hA);

        // both request from reset: strict alternation, icache first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.ic_addr = 32'h0000_3008;
        bus.dc_addr = 32'h0000_4010;
        bus.ic_read = 1'b1;
        bus.dc_read = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            bit d;
            d = k[0];
            read_txn(d, d ? 32'h0000_4000 : 32'h0000_3000, k % 2,
                     64'(k) << 8);
            if (d) bus.dc_read = 1'b1;
            else   bus.ic_read = 1'b1;
        end
        bus.ic_read = 1'b0;
        bus.dc_read = 1'b0;
        #1;

        // dcache writeback with stalls
        wbeat[0] = 64'h1111_1111_1111_1111;
        wbeat[1] = 64'h2222_2222_2222_2222;
        wbeat[2] = 64'h3333_3333_3333_3333;
        wbeat[3] = 64'h4444_4444_4444_4444;
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        bus.dc_addr  = 32'h8000_0040;
        bus.dc_wdata = {wbeat[3], wbeat[2], wbeat[1], wbeat[0]};
        bus.dc_write = 1'b1;
        #1;
        check("wr_idle", 64'(bus.bfp_write), 0);
        tick();
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            bus.bfp_ready = pat[c];
            #1;
            check("wr_vld", 64'(bus.bfp_write), 1);
            check("wr_addr", 64'(bus.bfp_addr), 64'h8000_0040);
            check("wr_data", bus.bfp_wdata, wbeat[idx]);
            check("wr_dcrdy", 64'(bus.dc_ready),
                  64'(pat[c] && idx == 3));
            tick();
            if (pat[c]) idx++;
        end
        bus.bfp_ready = 1'b0;
        bus.dc_write  = 1'b0;
        #1;
        idle_outs("post_wr");

        // reset in the middle of a read burst
        bus.ic_addr = 32'h0000_2000;
        bus.ic_read = 1'b1;
        tick();
        bus.bfp_ready = 1'b1;
        #1;
        check("mr_rdy", 64'(bus.ic_ready), 1);
        tick();
        bus.bfp_ready = 1'b0;
        bus.ic_read   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.bfp_rvalid = 1'b1;
            bus.bfp_rdata  = 64'h55 + 64'(i);
            bus.bfp_raddr  = 32'h0000_2000;
            #1;
            check("mr_beat", 64'(bus.ic_rvalid), 1);
            tick();
        end
        bus.bfp_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.bfp_rvalid = 1'b1;
            bus.bfp_rdata  = 64'hDEAD + 64'(i);
            #1;
            idle_outs("stray");
            tick();
        end
        bus.bfp_rvalid = 1'b0;
        bus.ic_addr = 32'h0000_5000;
        bus.dc_addr = 32'h0000_6000;
        bus.ic_read = 1'b1;
        bus.dc_read = 1'b1;
        #1;
        read_txn(1'b0, 32'h0000_5000, 0, 64'h70);
        read_txn(1'b1, 32'h0000_6000, 1, 64'h80);

        // garbage beat while idle
        bus.bfp_rvalid = 1'b1;
        bus.bfp_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        bus.bfp_raddr  = 32'hFFFF_FFE0;
        #1;
        idle_outs("idle_beat");
        tick();
        bus.bfp_rvalid = 1'b0;
        #1;
        idle_outs("idle_after");
        check("idle_addr", 64'(bus.bfp_addr), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
